// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// imem_pkg : shared states, error codes and word size for imem_loader
// Revision : 1.0
// ============================================================================
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OVERSIZE = 2'b01;
  localparam logic [1:0] ERR_CSUM     = 2'b10;

  localparam int BYTES_PER_WORD = 4;

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : framed byte-stream loader that fills instruction memory
//               (length, big-endian words, optional checksum byte).
// Optional feature: IMEM_LOADER_CHECKSUM_EN adds the trailing XOR checksum.
// Revision : 1.0
// ============================================================================
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DEPTH_BYTES = 76
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  state_e            state_q, state_d;
  logic [9:0]        cnt_q, cnt_d;
  logic [9:0]        total_q, total_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [1:0]        err_code_q, err_code_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic       busy;
  logic       accept;
  logic [9:0] len_bytes;

  // in_ready is a pure function of state so no input-to-output path exists.
  assign busy      = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  assign accept    = in_valid && busy;
  assign len_bytes = 10'(in_data) * 10'(BYTES_PER_WORD);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    total_d    = total_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_code_d = err_code_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LEN;
          cnt_d      = '0;
          total_d    = '0;
          err_code_d = ERR_NONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      LEN: begin
        if (accept) begin
          total_d = len_bytes;
          cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = in_data;
`endif
          // Oversize is rejected before any write, so the address never wraps.
          if (len_bytes > 10'(DEPTH_BYTES)) begin
            state_d    = ERR;
            err_code_d = ERR_OVERSIZE;
          end else if (in_data == 8'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = in_data;
          cnt_d     = cnt_q + 10'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d    = csum_q ^ in_data;
`endif
          if (cnt_q == total_q - 10'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d = DONE;
          end else begin
            state_d    = ERR;
            err_code_d = ERR_CSUM;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      total_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_code_q <= ERR_NONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      total_q    <= total_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_code_q <= err_code_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign in_ready = busy;
  assign cpu_hold = busy;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = (state_q == DONE);
  assign error    = (state_q == ERR);
  assign err_code = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// tb_imem_loader : self-checking bench for imem_loader (directed + random
//                  frames against a frame-level reference model).
// Revision : 1.0
// ============================================================================
module tb_imem_loader;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 76;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, start, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, wr_en, cpu_hold, done, error;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [1:0]        err_code;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH_BYTES(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_hold(cpu_hold), .done(done), .error(error),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;
  wr_t wr_q[$];
  int  hs_q[$];

  always @(negedge clk) begin
    if (wr_en === 1'b1) wr_q.push_back('{addr: int'(wr_addr), data: int'(wr_data), cyc: cyc});
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    wr_q.delete();
    hs_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ready_after_start", in_ready, 1);
  endtask

  // mode 0: always valid, 1: toggle 1/0 each cycle, 2: random gaps.
  task automatic send(input logic [7:0] fr[$], input int mode, input int start_at);
    int idx = 0;
    int guard = 0;
    bit ph = 1'b1;
    bit v, rdy;
    int ncyc;
    while (idx < fr.size() && guard < 600) begin
      @(negedge clk);
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(0, 1));
      ph = !ph;
      in_valid = v;
      in_data  = fr[idx];
      start    = (idx == start_at);
      rdy      = in_ready;
      ncyc     = cyc;
      @(posedge clk);
      if (start) start_at = -1;
      if (v && rdy) begin
        hs_q.push_back(ncyc);
        idx++;
      end
      guard++;
    end
    check("bytes_accepted", idx, fr.size());
  endtask

  task automatic run_frame(input string tag, input int n, input logic [7:0] data[$],
                           input logic [7:0] csum, input int mode, input int start_at);
    logic [7:0] fr[$];
    logic [7:0] x;
    bit         over;
    int         exp_err, exp_writes;
    over = (4 * n) > DEPTH;
    x = 8'(n);
    foreach (data[i]) x ^= data[i];
    fr.push_back(8'(n));
    if (!over) begin
      foreach (data[i]) fr.push_back(data[i]);
      if (CSUM_EN) fr.push_back(csum);
    end
    exp_err    = over ? 1 : (CSUM_EN && csum != x) ? 2 : 0;
    exp_writes = over ? 0 : 4 * n;

    pulse_start();
    send(fr, mode, start_at);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    check({tag, "_done"},     done,     (exp_err == 0));
    check({tag, "_error"},    error,    (exp_err != 0));
    check({tag, "_err_code"}, err_code, exp_err);
    check({tag, "_cpu_hold"}, cpu_hold, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    @(negedge clk);
    check({tag, "_n_writes"}, wr_q.size(), exp_writes);
    for (int k = 0; k < exp_writes && k < wr_q.size(); k++) begin
      check({tag, "_wr_addr"}, wr_q[k].addr, k);
      check({tag, "_wr_data"}, wr_q[k].data, data[k]);
      check({tag, "_wr_cyc"},  wr_q[k].cyc,  hs_q[k + 1] + 1);
    end
  endtask

  function automatic logic [7:0] xsum(input int n, input logic [7:0] d[$]);
    logic [7:0] x = 8'(n);
    foreach (d[i]) x ^= d[i];
    return x;
  endfunction

  initial begin
    logic [7:0] d[$];
    logic [7:0] fr[$];
    int         n;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en",    wr_en,    0);
    check("rst_wr_addr",  wr_addr,  0);
    check("rst_wr_data",  wr_data,  0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_done",     done,     0);
    check("rst_error",    error,    0);
    check("rst_err_code", err_code, 0);

    d = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    run_frame("n2", 2, d, xsum(2, d), 0, -1);

    d.delete();
    run_frame("oversize", 20, d, 8'h00, 0, -1);

    d = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("badcsum", 1, d, 8'hFF, 0, -1);

    d.delete();
    for (int i = 0; i < 12; i++) d.push_back(8'($urandom));
    run_frame("toggle", 3, d, xsum(3, d), 1, -1);

    run_frame("start_in_data", 3, d, xsum(3, d), 0, 6);

    d.delete();
    run_frame("n0", 0, d, 8'h00, 0, -1);

    d.delete();
    for (int i = 0; i < 76; i++) d.push_back(8'($urandom));
    run_frame("n19_max", 19, d, xsum(19, d), 2, -1);

    // Reset mid-load after the 5th data byte of an N=4 frame.
    pulse_start();
    fr = '{8'd4, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send(fr, 0, -1);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_wr_en",    wr_en,    0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_cpu_hold", cpu_hold, 0);
    check("midrst_done",     done,     0);
    check("midrst_error",    error,    0);
    check("midrst_err_code", err_code, 0);
    check("midrst_wr_addr",  wr_addr,  0);
    check("midrst_n_writes", wr_q.size(), 5);
    d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    run_frame("reload", 2, d, xsum(2, d), 0, -1);

    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(0, 19);
      d.delete();
      for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
      run_frame("rand", n, d,
                ($urandom_range(0, 3) == 0) ? 8'(xsum(n, d) ^ 8'h5A) : xsum(n, d),
                $urandom_range(0, 2), -1);
    end

    d.delete();
    run_frame("rand_over", $urandom_range(20, 255), d, 8'h00, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
